// File: rtl/sprite_render_pkg.sv
// sprite_render_pkg: shared screen, colour and sprite-geometry constants.
package sprite_render_pkg;
  localparam int COORD_WIDTH = 10;
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  typedef logic [11:0] rgb444_t;
  localparam rgb444_t TRANSPARENT_KEY = 12'h0F0;
  localparam int SPRITE_W = 73;
  localparam int SPRITE_H = 65;
  localparam int SPRITE_FRAMES = 2;
  localparam int SPRITE_ANIM_DIV = 8;
endpackage

// File: rtl/sprite_render_anim_ctrl.sv
// sprite_anim_ctrl: steps the animation frame every ANIM_DIV frame_start pulses
// and keeps the ROM base address of the current frame registered.
module sprite_anim_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int SPRITE_W = 73,
  parameter int SPRITE_H = 65,
  parameter int NUM_FRAMES = 2,
  parameter int ANIM_DIV = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  anim_en,
  output logic [ADDR_WIDTH-1:0] frame_base
);
  localparam int FW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1;
  localparam int CW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
  logic [CW-1:0] r_anim_cnt;
  logic [FW-1:0] r_frame_idx;
  logic          w_step;
  logic [FW-1:0] w_idx_nxt;
  assign w_step = frame_start && anim_en && r_anim_cnt == CW'(ANIM_DIV - 1);
  assign w_idx_nxt = w_step ? (r_frame_idx == FW'(NUM_FRAMES - 1) ? '0 : r_frame_idx + 1'b1) : r_frame_idx;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_anim_cnt  <= '0;
      r_frame_idx <= '0;
      frame_base  <= '0;
    end else if (frame_start && anim_en) begin
      r_anim_cnt  <= w_step ? '0 : r_anim_cnt + 1'b1;
      r_frame_idx <= w_idx_nxt;
      frame_base  <= ADDR_WIDTH'(w_idx_nxt) * ADDR_WIDTH'(SPRITE_W * SPRITE_H);
    end
  end
endmodule

// File: rtl/sprite_render.sv
// sprite_render: drives a registered sprite ROM from the scan position and
// realigns its data into a registered colour/hit pair three edges later.
module sprite_render
  import sprite_render_pkg::*;
#(
  parameter int      DATA_WIDTH      = 12,
  parameter int      ADDR_WIDTH      = 14,
  parameter int      COORD_WIDTH     = sprite_render_pkg::COORD_WIDTH,
  parameter int      SPRITE_W        = sprite_render_pkg::SPRITE_W,
  parameter int      SPRITE_H        = sprite_render_pkg::SPRITE_H,
  parameter int      NUM_FRAMES      = SPRITE_FRAMES,
  parameter int      ANIM_DIV        = SPRITE_ANIM_DIV,
  parameter rgb444_t TRANSPARENT_KEY = sprite_render_pkg::TRANSPARENT_KEY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COORD_WIDTH-1:0] pixel_x,
  input  logic [COORD_WIDTH-1:0] pixel_y,
  input  logic                   frame_start,
  input  logic [COORD_WIDTH-1:0] pos_x,
  input  logic [COORD_WIDTH-1:0] pos_y,
  input  logic                   anim_en,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  output logic [DATA_WIDTH-1:0]  rgb_o,
  output logic                   hit_o
);
  logic [COORD_WIDTH-1:0] r_pos_x, r_pos_y;
  logic [ADDR_WIDTH-1:0]  w_frame_base, w_addr;
  logic [COORD_WIDTH:0]   w_x_end, w_y_end;
  logic                   w_in_box, r_in_box_d1, r_in_box_d2, w_hit;
  sprite_anim_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H),
    .NUM_FRAMES(NUM_FRAMES),
    .ANIM_DIV(ANIM_DIV)
  ) u_anim (
    .clk(clk),
    .reset(reset),
    .frame_start(frame_start),
    .anim_en(anim_en),
    .frame_base(w_frame_base)
  );
  // One extra bit so a box hanging off the right/bottom edge never wraps.
  assign w_x_end = {1'b0, r_pos_x} + (COORD_WIDTH + 1)'(SPRITE_W);
  assign w_y_end = {1'b0, r_pos_y} + (COORD_WIDTH + 1)'(SPRITE_H);
  assign w_in_box = pixel_x >= r_pos_x && {1'b0, pixel_x} < w_x_end &&
                    pixel_y >= r_pos_y && {1'b0, pixel_y} < w_y_end;
  assign w_addr = w_in_box ? w_frame_base + ADDR_WIDTH'(pixel_y - r_pos_y) * ADDR_WIDTH'(SPRITE_W)
                             + ADDR_WIDTH'(pixel_x - r_pos_x) : '0;
  assign w_hit = r_in_box_d2 && rom_data != DATA_WIDTH'(TRANSPARENT_KEY);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      rom_addr    <= '0;
      r_in_box_d1 <= 1'b0;
      r_in_box_d2 <= 1'b0;
      hit_o       <= 1'b0;
      rgb_o       <= '0;
    end else begin
      if (frame_start) begin
        r_pos_x <= pos_x;
        r_pos_y <= pos_y;
      end
      rom_addr    <= w_addr;
      r_in_box_d1 <= w_in_box;
      r_in_box_d2 <= r_in_box_d1;
      hit_o       <= w_hit;
      rgb_o       <= w_hit ? rom_data : '0;
    end
  end
endmodule

// File: tb/tb_sprite_render.sv
// tb_sprite_render: directed vectors against a small registered ROM model.
module tb_sprite_render;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pixel_x = '0, pixel_y = '0, pos_x = '0, pos_y = '0;
  logic        frame_start = 1'b0, anim_en = 1'b0;
  logic [13:0] rom_addr;
  logic [11:0] rom_data = '0, rgb_o;
  logic        hit_o;
  int          n_cmp = 0, n_err = 0;

  sprite_render #(.ANIM_DIV(4)) dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .anim_en(anim_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .rgb_o(rgb_o), .hit_o(hit_o)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_model(input logic [13:0] a);
    return a == 14'd0 ? 12'hABC : a == 14'd1 ? 12'h0F0 : a == 14'd4744 ? 12'h123 :
           a == 14'd4745 ? 12'h456 : 12'h777;
  endfunction

  always @(posedge clk) rom_data <= rom_model(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [13:0] exp_addr,
                     input logic exp_hit, input logic [11:0] exp_rgb);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    tick();
    check({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
    tick();
    tick();
    check({tag, ".hit"}, 32'(hit_o), 32'(exp_hit));
    check({tag, ".rgb"}, 32'(rgb_o), 32'(exp_rgb));
  endtask

  initial begin
    tick();
    check("rst.addr", 32'(rom_addr), 0);
    check("rst.rgb", 32'(rgb_o), 0);
    check("rst.hit", 32'(hit_o), 0);
    reset = 1'b0;
    tick();
    pos_x = 10'd100;
    pos_y = 10'd50;
    pulse(1);
    pix("p100_50", 100, 50, 14'd0, 1'b1, 12'hABC);
    pix("p172_114", 172, 114, 14'd4744, 1'b1, 12'h123);
    pix("left", 99, 50, 14'd0, 1'b0, 12'h000);
    pix("right", 173, 50, 14'd0, 1'b0, 12'h000);
    pix("below", 100, 115, 14'd0, 1'b0, 12'h000);
    pix("transp", 101, 50, 14'd1, 1'b0, 12'h000);
    anim_en = 1'b1;
    pulse(4);
    pix("anim4", 100, 50, 14'd4745, 1'b1, 12'h456);
    pulse(4);
    pix("anim8", 100, 50, 14'd0, 1'b1, 12'hABC);
    pulse(2);
    anim_en = 1'b0;
    pulse(4);
    pix("hold", 100, 50, 14'd0, 1'b1, 12'hABC);
    anim_en = 1'b1;
    pulse(2);
    anim_en = 1'b0;
    pix("resume", 100, 50, 14'd4745, 1'b1, 12'h456);
    pos_x = 10'd200;
    pix("nolatch", 100, 50, 14'd4745, 1'b1, 12'h456);
    reset = 1'b1;
    #1;
    check("arst.addr", 32'(rom_addr), 0);
    check("arst.rgb", 32'(rgb_o), 0);
    check("arst.hit", 32'(hit_o), 0);
    tick();
    tick();
    tick();
    reset = 1'b0;
    pix("post_rst", 1, 0, 14'd1, 1'b0, 12'h000);
    pix("post_rst0", 0, 0, 14'd0, 1'b1, 12'hABC);
    pos_x = 10'd1000;
    pos_y = 10'd50;
    pulse(1);
    pix("nowrap", 5, 50, 14'd0, 1'b0, 12'h000);
    pix("p1000", 1000, 50, 14'd0, 1'b1, 12'hABC);
    pos_x = 10'd100;
    pixel_x = 10'd1001;
    pixel_y = 10'd50;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("simul.old", 32'(rom_addr), 1);
    pixel_x = 10'd101;
    tick();
    check("simul.new", 32'(rom_addr), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end
endmodule

// File: doc/sprite_render.md
Name: sprite_render

Overview:
- Consumer/driver stage for a synchronous sprite ROM: 12-bit RGB, one-cycle registered read, multiple animation frames stored back to back.
- Takes the current VGA pixel coordinate and the sprite's on-screen position, and generates the ROM address.
- Realigns the ROM data with a pipelined in-box flag and emits a registered pixel colour plus a hit flag for the display mux.
- Handles animation frame selection and colour-key transparency.

Parameters:
- DATA_WIDTH, 12, pixel colour width (RGB444).
- ADDR_WIDTH, 14, ROM address width.
- COORD_WIDTH, 10, pixel_x/pixel_y/pos width.
- SPRITE_W, 73, sprite width in pixels.
- SPRITE_H, 65, sprite height in pixels.
- NUM_FRAMES, 2, animation frames in ROM; ROM size = SPRITE_W*SPRITE_H*NUM_FRAMES = 9490.
- ANIM_DIV, 8, frame_start pulses per animation step.
- TRANSPARENT_KEY, 12'h0F0, colour treated as transparent.

Ports:
- clk  in  1  system/pixel-pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- pixel_x  in  COORD_WIDTH  current scan column.
- pixel_y  in  COORD_WIDTH  current scan row.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- pos_x  in  COORD_WIDTH  sprite left edge, requested.
- pos_y  in  COORD_WIDTH  sprite top edge, requested.
- anim_en  in  1  enables animation advance.
- rom_addr  out  ADDR_WIDTH  address to sprite ROM.
- rom_data  in  DATA_WIDTH  ROM output, valid one edge after rom_addr.
- rgb_o  out  DATA_WIDTH  sprite pixel colour, 0 when no hit.
- hit_o  out  1  sprite pixel opaque at this coordinate.

Behaviour:
- Reset (async, immediate): every output and all registers go to 0: rom_addr, rgb_o, hit_o, latched position, frame_idx, anim count.
- Position latch: pos_x_q/pos_y_q load pos_x/pos_y only on a clk edge where frame_start=1. Position changes mid-frame have no effect until the next frame_start.
- Animation: on frame_start with anim_en=1, anim_cnt increments.
  - When anim_cnt reaches ANIM_DIV-1 it wraps to 0 and frame_idx increments modulo NUM_FRAMES.
  - frame_base = frame_idx*SPRITE_W*SPRITE_H is registered and updated on the same edge.
  - anim_en=0 holds anim_cnt and frame_idx.
- Box test (combinational on the inputs):
  - in_box = pixel_x >= pos_x_q && pixel_x < pos_x_q+SPRITE_W && pixel_y >= pos_y_q && pixel_y < pos_y_q+SPRITE_H.
  - Sums are computed COORD_WIDTH+1 wide, so a box crossing 1023 never wraps to small coordinates.
- Stage 1, edge N:
  - rom_addr <= frame_base + (pixel_y-pos_y_q)*SPRITE_W + (pixel_x-pos_x_q) when in_box, else 0.
  - in_box_d1 <= in_box.
  - Arithmetic is ADDR_WIDTH wide, unsigned. The maximum address is ROM_SIZE-1 by construction.
- Stage 2, edge N+1: in_box_d2 <= in_box_d1. rom_data now holds ROM[rom_addr].
- Stage 3, edge N+2:
  - hit_o <= in_box_d2 && (rom_data != TRANSPARENT_KEY).
  - rgb_o <= hit_o-next ? rom_data : 0.
- Latency: coordinates presented before edge N appear on rgb_o/hit_o after edge N+2. The pipeline advances every clk, with no stalls.
- Simultaneous events: frame_start coincident with an in-box pixel causes that pixel to use the old position and old frame_base. New values apply from the next edge.
- There is no FSM beyond the animation counter. Throughput is one pixel per clk.

Decomposition:
- Shared package holds:
  - TRANSPARENT_KEY.
  - COORD_WIDTH.
  - Screen constants (H_VISIBLE=640, V_VISIBLE=480).
  - RGB444 colour typedef.
  - Sprite geometry constants per sprite (width, height, frame count).
- Sub-module sprite_anim_ctrl holds anim_cnt, frame_idx and frame_base register. Its inputs are frame_start, anim_en and reset; its output is frame_base.
- sprite_render instantiates sprite_anim_ctrl and contains the box test and the 3-stage pipeline.

Test Plan:
- Reset held 3 cycles mid-operation -> rom_addr=0, rgb_o=0, hit_o=0 immediately (async); frame_idx=0 after release.
- pos=(100,50) latched by frame_start; ROM model stores 12'hABC at 0 and 12'h123 at 4744. Pixel (100,50) -> rom_addr=0 after 1 edge, rgb_o=12'hABC and hit_o=1 after 3rd edge. Pixel (172,114) -> rom_addr=4744, rgb_o=12'h123.
- Pixels (99,50), (173,50) and (100,115) with pos=(100,50) -> rom_addr=0, hit_o=0, rgb_o=0.
- In-box pixel where ROM returns 12'h0F0 -> hit_o=0, rgb_o=0.
- ANIM_DIV=4, anim_en=1:
  - 4 frame_start pulses -> pixel (100,50) gives rom_addr=4745.
  - 8 pulses -> wraps back to rom_addr=0.
  - anim_en=0 for 4 pulses -> address unchanged.
- Position and edge cases:
  - pos_x changed to 200 without frame_start -> pixel (100,50) still hits.
  - After frame_start with pos_x=1000, pos_y=50 -> pixel (5,50) hit_o=0 (no wrap), pixel (1000,50) rom_addr=0.
